// File: rtl/seq_shift_unit.sv
// Iterative shifter: moves up to STEP bit positions per cycle behind a start/busy/done handshake.
// Define SEQ_SHIFT_ROTATE_EN to honour the rot input (rotate mode).
module seq_shift_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [31:0]      shamt,
  input  logic             dir,
  input  logic             aorl,
  input  logic             rot,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);
  localparam int unsigned LW = $clog2(WIDTH);
  localparam int unsigned RW = LW + 1;
  localparam logic [WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             aorl_q, aorl_d;
  logic             sign_q, sign_d;
  logic             rot_q, rot_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             rot_in_c;
  logic [RW-1:0]    rem_acc_c;
  logic [RW-1:0]    step_c;
  logic [WIDTH-1:0] fill_c;
  logic [WIDTH-1:0] shifted_c;

`ifdef SEQ_SHIFT_ROTATE_EN
  assign rot_in_c = rot;
`else
  logic rot_unused;
  assign rot_in_c   = 1'b0;
  assign rot_unused = rot;
`endif

  // Remaining distance at acceptance: rotate wraps, plain shifts saturate at WIDTH.
  always_comb begin
    if (rot_in_c) begin
      rem_acc_c = {1'b0, shamt[LW-1:0]};
    end else if (shamt >= 32'(WIDTH)) begin
      rem_acc_c = RW'(WIDTH);
    end else begin
      rem_acc_c = {1'b0, shamt[LW-1:0]};
    end
  end

  // One iteration of the datapath, moving step_c positions.
  always_comb begin
    step_c    = (rem_q > RW'(STEP)) ? RW'(STEP) : rem_q;
    fill_c    = (aorl_q && sign_q) ? ~(ONES >> step_c) : '0;
    shifted_c = out_q << step_c;
    if (rot_q) begin
`ifdef SEQ_SHIFT_ROTATE_EN
      if (dir_q) begin
        shifted_c = (out_q >> step_c) | (out_q << (RW'(WIDTH) - step_c));
      end else begin
        shifted_c = (out_q << step_c) | (out_q >> (RW'(WIDTH) - step_c));
      end
`endif
    end else if (dir_q) begin
      shifted_c = (out_q >> step_c) | fill_c;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    aorl_d  = aorl_q;
    sign_d  = sign_q;
    rot_d   = rot_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          out_d   = in;
          rem_d   = rem_acc_c;
          dir_d   = dir;
          aorl_d  = aorl;
          sign_d  = in[WIDTH-1];
          rot_d   = rot_in_c;
          state_d = (rem_acc_c == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        out_d = shifted_c;
        rem_d = rem_q - step_c;
        if (rem_q <= RW'(STEP)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      aorl_q  <= 1'b0;
      sign_q  <= 1'b0;
      rot_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      aorl_q  <= aorl_d;
      sign_q  <= sign_d;
      rot_q   <= rot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
